// File: rtl/maxpool_stream_reader_if.sv
// Output beat bus of the max-pool reader: one pooled window maximum per
// valid/ready handshake, tagged with its pooled row/column and a last flag.
interface maxpool_stream_reader_if #(
  parameter int WIDTH_BIT = 16
);
  logic                        outValid;
  logic                        outReady;
  logic signed [WIDTH_BIT-1:0] outData;
  logic        [WIDTH_BIT-1:0] outRow;
  logic        [WIDTH_BIT-1:0] outCol;
  logic                        outLast;

  modport master (
    output outValid, outData, outRow, outCol, outLast,
    input  outReady
  );

  modport slave (
    input  outValid, outData, outRow, outCol, outLast,
    output outReady
  );
endinterface

// File: rtl/maxpool_stream_reader.sv
// Scans a finished conv feature map in non-overlapping POOL x POOL windows,
// row-major, and streams each window's signed maximum on a valid/ready bus.
module maxpool_stream_reader #(
  parameter int SIZE      = 318,
  parameter int POOL      = 2,
  parameter int WIDTH_BIT = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic signed [WIDTH_BIT-1:0] featIn [SIZE-1:0][SIZE-1:0],
  maxpool_stream_reader_if.master     outBus,
  output logic                        busy,
  output logic                        done
);

  localparam int NOUT = SIZE / POOL;
  localparam int AW   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int PW   = (POOL > 1) ? $clog2(POOL) : 1;

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t state, stateNext;

  logic        [AW-1:0]        rowIdx, colIdx;
  logic        [PW-1:0]        kIdx, lIdx;
  logic        [AW-1:0]        pixRow, pixCol;
  logic signed [WIDTH_BIT-1:0] acc, accNext, pixel;
  logic signed [WIDTH_BIT-1:0] outDataQ;
  logic        [WIDTH_BIT-1:0] outRowQ, outColQ;
  logic                        firstElem, lastElem, lastWin;

  function automatic logic signed [WIDTH_BIT-1:0] smax(
    input logic signed [WIDTH_BIT-1:0] a,
    input logic signed [WIDTH_BIT-1:0] b
  );
    return (b > a) ? b : a;
  endfunction

  // Window element addressing and running maximum
  always_comb begin
    pixRow    = AW'(int'(rowIdx) * POOL + int'(kIdx));
    pixCol    = AW'(int'(colIdx) * POOL + int'(lIdx));
    pixel     = featIn[pixRow][pixCol];
    firstElem = (kIdx == '0) && (lIdx == '0);
    lastElem  = (kIdx == PW'(POOL - 1)) && (lIdx == PW'(POOL - 1));
    lastWin   = (rowIdx == AW'(NOUT - 1)) && (colIdx == AW'(NOUT - 1));
    accNext   = firstElem ? pixel : smax(acc, pixel);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (start) stateNext = ACC;
      ACC:     if (lastElem) stateNext = OUT;
      OUT:     if (outBus.outReady) stateNext = lastWin ? IDLE : ACC;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    outBus.outValid = (state == OUT);
    outBus.outLast  = (state == OUT) && lastWin;
    outBus.outData  = outDataQ;
    outBus.outRow   = outRowQ;
    outBus.outCol   = outColQ;
    busy            = (state != IDLE);
  end

  // Counters, accumulator and held beat; beat registers only change when a
  // new window completes, so they keep their value while outValid is low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rowIdx   <= '0;
      colIdx   <= '0;
      kIdx     <= '0;
      lIdx     <= '0;
      acc      <= '0;
      outDataQ <= '0;
      outRowQ  <= '0;
      outColQ  <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            rowIdx <= '0;
            colIdx <= '0;
            kIdx   <= '0;
            lIdx   <= '0;
          end
        end
        ACC: begin
          acc <= accNext;
          if (lIdx == PW'(POOL - 1)) begin
            lIdx <= '0;
            kIdx <= lastElem ? '0 : kIdx + PW'(1);
          end else begin
            lIdx <= lIdx + PW'(1);
          end
          if (lastElem) begin
            outDataQ <= accNext;
            outRowQ  <= WIDTH_BIT'(rowIdx);
            outColQ  <= WIDTH_BIT'(colIdx);
          end
        end
        OUT: begin
          if (outBus.outReady) begin
            if (lastWin) begin
              done <= 1'b1;
            end else if (colIdx == AW'(NOUT - 1)) begin
              colIdx <= '0;
              rowIdx <= rowIdx + AW'(1);
            end else begin
              colIdx <= colIdx + AW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_stream_reader.sv
// Scoreboard bench for maxpool_stream_reader: a 4x4 and a 5x5 instance, both
// with 2x2 pooling, checked against a window-max reference model.
module tb_maxpool_stream_reader;

  localparam int W = 16;

  typedef struct {
    int data;
    int row;
    int col;
    int last;
  } beat_t;

  logic clock = 1'b0;
  logic reset;
  logic start4, start5;
  logic busy4, done4, busy5, done5;
  logic signed [W-1:0] feat4 [3:0][3:0];
  logic signed [W-1:0] feat5 [4:0][4:0];

  always #5 clock = ~clock;

  maxpool_stream_reader_if #(.WIDTH_BIT(W)) if4 ();
  maxpool_stream_reader_if #(.WIDTH_BIT(W)) if5 ();

  maxpool_stream_reader #(.SIZE(4), .POOL(2), .WIDTH_BIT(W)) dut4 (
    .clock(clock), .reset(reset), .start(start4), .featIn(feat4),
    .outBus(if4), .busy(busy4), .done(done4)
  );

  maxpool_stream_reader #(.SIZE(5), .POOL(2), .WIDTH_BIT(W)) dut5 (
    .clock(clock), .reset(reset), .start(start5), .featIn(feat5),
    .outBus(if5), .busy(busy5), .done(done5)
  );

  assign if5.outReady = 1'b1;

  int    cyc = 0;
  int    nVec = 0;
  int    nErr = 0;
  beat_t q4[$];
  beat_t q5[$];
  int    hs4[$];
  int    doneCyc4 = -1;
  int    beats5 = 0;
  bit    done5Seen = 1'b0;
  int    rdyMode4 = 0;
  int    img [5][5];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // 0: ready held high, 1: random ready, 2: ready held low
  always @(posedge clock) begin
    #1;
    case (rdyMode4)
      0:       if4.outReady = 1'b1;
      1:       if4.outReady = 1'($urandom_range(0, 1));
      default: if4.outReady = 1'b0;
    endcase
  end

  bit    stall4 = 1'b0;
  beat_t held4;
  beat_t e4;

  always @(negedge clock) begin
    if (reset) begin
      stall4 = 1'b0;
    end else begin
      if (stall4) begin
        chk("hold_valid", if4.outValid, 1);
        chk("hold_data", if4.outData, held4.data);
        chk("hold_row", if4.outRow, held4.row);
        chk("hold_col", if4.outCol, held4.col);
      end
      if (if4.outValid) chk("busy_in_out", busy4, 1);
      if (if4.outValid && if4.outReady) begin
        if (q4.size() == 0) begin
          chk("extra_beat4", q4.size(), 1);
        end else begin
          e4 = q4.pop_front();
          chk("beat_data", if4.outData, e4.data);
          chk("beat_row", if4.outRow, e4.row);
          chk("beat_col", if4.outCol, e4.col);
          chk("beat_last", if4.outLast, e4.last);
        end
        hs4.push_back(cyc);
      end
      stall4     = if4.outValid && !if4.outReady;
      held4.data = int'(if4.outData);
      held4.row  = int'(if4.outRow);
      held4.col  = int'(if4.outCol);
      if (done4) begin
        doneCyc4 = cyc;
        chk("busy_at_done", busy4, 0);
      end
    end
  end

  beat_t e5;

  always @(negedge clock) begin
    if (!reset) begin
      if (if5.outValid && if5.outReady) begin
        if (q5.size() == 0) begin
          chk("extra_beat5", q5.size(), 1);
        end else begin
          e5 = q5.pop_front();
          chk("b5_data", if5.outData, e5.data);
          chk("b5_row", if5.outRow, e5.row);
          chk("b5_col", if5.outCol, e5.col);
          chk("b5_last", if5.outLast, e5.last);
        end
        beats5++;
      end
      if (done5) done5Seen = 1'b1;
    end
  end

  // Reference: every complete 2x2 window, row-major, signed maximum.
  task automatic model(input int size, input bit to5);
    int    n;
    int    m;
    beat_t b;
    n = size / 2;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        m = img[2*r][2*c];
        for (int k = 0; k < 2; k++)
          for (int l = 0; l < 2; l++)
            if (img[2*r+k][2*c+l] > m) m = img[2*r+k][2*c+l];
        b = '{m, r, c, int'(r == n-1 && c == n-1)};
        if (to5) q5.push_back(b);
        else     q4.push_back(b);
      end
    end
  endtask

  task automatic load4();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) feat4[i][j] = 16'(img[i][j]);
  endtask

  task automatic load5();
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) feat5[i][j] = 16'(img[i][j]);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) img[i][j] = i * 4 + j;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) img[i][j] = int'($signed(16'($urandom)));
  endtask

  task automatic pulse_start(input bit which, output int s);
    @(posedge clock); #1;
    if (which) start5 = 1'b1;
    else       start4 = 1'b1;
    s = cyc + 1;
    @(posedge clock); #1;
    start4 = 1'b0;
    start5 = 1'b0;
  endtask

  task automatic run4(input string tag, input int mode, input bit midStart,
                      input bit bp, input bit timing);
    int s;
    bit sawOut;
    bit bpOn;
    int bpCnt;
    sawOut = 1'b0;
    bpOn   = 1'b0;
    bpCnt  = 0;
    hs4.delete();
    doneCyc4 = -1;
    rdyMode4 = mode;
    load4();
    model(4, 1'b0);
    pulse_start(1'b0, s);
    for (int i = 0; i < 600 && doneCyc4 < 0; i++) begin
      @(negedge clock); #1;
      if (midStart) begin
        if (start4) start4 = 1'b0;
        else if (i == 1) start4 = 1'b1;
        else if (if4.outValid && !sawOut) begin
          start4 = 1'b1;
          sawOut = 1'b1;
        end
      end
      if (bp) begin
        if (hs4.size() == 1 && !bpOn && bpCnt == 0) begin
          rdyMode4 = 2;
          bpOn     = 1'b1;
        end else if (bpOn && if4.outValid) begin
          bpCnt++;
          if (bpCnt == 10) begin
            rdyMode4 = 0;
            bpOn     = 1'b0;
          end
        end
      end
    end
    start4 = 1'b0;
    chk({tag, "_done_seen"}, doneCyc4 >= 0, 1);
    chk({tag, "_beats"}, hs4.size(), 4);
    chk({tag, "_left"}, q4.size(), 0);
    if (timing && hs4.size() == 4) begin
      chk({tag, "_first_lat"}, hs4[0] - s, 4);
      for (int k = 1; k < 4; k++) chk({tag, "_gap"}, hs4[k] - hs4[k-1], 5);
      chk({tag, "_done_lat"}, doneCyc4 - hs4[3], 1);
    end
    @(negedge clock); #1;
    chk({tag, "_done_pulse"}, done4, 0);
    chk({tag, "_busy_idle"}, busy4, 0);
    rdyMode4 = 0;
    q4.delete();
  endtask

  initial begin
    int s;
    reset  = 1'b1;
    start4 = 1'b0;
    start5 = 1'b0;
    fill_ramp();
    load4();
    load5();
    repeat (3) @(posedge clock);
    #3 reset = 1'b0;
    @(negedge clock); #1;
    chk("rst_valid", if4.outValid, 0);
    chk("rst_data", if4.outData, 0);
    chk("rst_row", if4.outRow, 0);
    chk("rst_col", if4.outCol, 0);
    chk("rst_last", if4.outLast, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);

    fill_ramp();
    run4("ramp", 0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) img[i][j] = -1;
    img[0][0] = -7; img[0][1] = -3; img[1][0] = -9; img[1][1] = -3;
    run4("negmax", 0, 1'b0, 1'b0, 1'b1);

    fill_rand();
    run4("bpress", 0, 1'b0, 1'b1, 1'b0);

    fill_ramp();
    run4("midstart", 0, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset while a beat is being presented and stalled
    fill_ramp();
    load4();
    rdyMode4 = 2;
    @(posedge clock); #2;
    model(4, 1'b0);
    pulse_start(1'b0, s);
    for (int i = 0; i < 50 && !if4.outValid; i++) @(negedge clock);
    chk("rst_reach_out", if4.outValid, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", if4.outValid, 0);
    chk("arst_data", if4.outData, 0);
    chk("arst_row", if4.outRow, 0);
    chk("arst_col", if4.outCol, 0);
    chk("arst_last", if4.outLast, 0);
    chk("arst_busy", busy4, 0);
    chk("arst_done", done4, 0);
    q4.delete();
    hs4.delete();
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    rdyMode4 = 0;
    run4("after_rst", 0, 1'b0, 1'b0, 1'b1);

    for (int n = 0; n < 5; n++) begin
      fill_rand();
      run4("rand", 1, 1'b0, 1'b0, 1'b0);
    end

    // 5x5 map: last row and column must never be pooled
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) img[i][j] = int'($urandom_range(0, 2000)) - 1000;
    for (int k = 0; k < 5; k++) begin
      img[4][k] = 32767;
      img[k][4] = 32767;
    end
    load5();
    model(5, 1'b1);
    pulse_start(1'b1, s);
    for (int i = 0; i < 200 && !done5Seen; i++) @(negedge clock);
    #1;
    chk("s5_done_seen", done5Seen, 1);
    chk("s5_beats", beats5, 4);
    chk("s5_left", q5.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
